// File: rtl/transformer_pkg.sv
// Shared Q16.16 constants, state encoding and MS-chunk-first tile layout helpers
// for the transformer front-end blocks.
package transformer_pkg;

   localparam logic [31:0] ONE_Q           = 32'h0001_0000;
   localparam logic [31:0] LN2_Q           = 32'h0000_B172;
   localparam logic [31:0] SCALE_Q_DEFAULT = 32'h0000_2000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // LSB position of element idx in an n-element bus; element 0 sits in the MS chunk.
   function automatic int unsigned ms_lsb(input int unsigned idx, input int unsigned n,
                                          input int unsigned w);
      return (n - 1 - idx) * w;
   endfunction

endpackage

// File: rtl/qmul_scale.sv
// One-lane signed fixed-point scale: y = (x * SCALE_Q) >>> FRAC_WIDTH.
// Define SCORE_SAT_EN to clamp overflowing results instead of wrapping.
module qmul_scale #(
   parameter int unsigned       WIDTH      = 32,
   parameter int unsigned       FRAC_WIDTH = 16,
   parameter logic [WIDTH-1:0]  SCALE_Q    = '0
) (
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y_c
);

   localparam int unsigned PW = 2 * WIDTH;

   logic signed [PW-1:0] p_c;

   assign p_c = PW'($signed(x)) * PW'($signed(SCALE_Q));

`ifdef SCORE_SAT_EN
   logic signed [PW-1:0] sh_c;
   logic                 ovf_c;

   assign sh_c  = p_c >>> FRAC_WIDTH;
   // Result fits only if every bit above the WIDTH-bit sign position matches the sign.
   assign ovf_c = (sh_c[PW-1:WIDTH-1] != {(PW-WIDTH+1){sh_c[PW-1]}});

   always_comb begin
      y_c = sh_c[WIDTH-1:0];
      if (ovf_c) begin
         y_c = sh_c[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   assign y_c = WIDTH'(p_c >>> FRAC_WIDTH);
`endif

endmodule

// File: rtl/score_tile_packer.sv
// Scales an attention-score row and packs it into TILE_SIZE-element tiles for softmax_vec.
// Optional saturation of the scaled values is enabled with `SCORE_SAT_EN (see qmul_scale).
module score_tile_packer
   import transformer_pkg::*;
#(
   parameter int unsigned      WIDTH          = 32,
   parameter int unsigned      FRAC_WIDTH     = 16,
   parameter int unsigned      TOTAL_ELEMENTS = 1024,
   parameter int unsigned      TILE_SIZE      = 16,
   parameter int unsigned      IN_LANES       = 4,
   parameter logic [WIDTH-1:0] SCALE_Q        = WIDTH'(SCALE_Q_DEFAULT)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic                          start,
   input  logic [IN_LANES*WIDTH-1:0]     x_in,
   input  logic                          x_in_valid,
   output logic                          x_in_ready,
   output logic [TILE_SIZE*WIDTH-1:0]    X_tile_out,
   output logic                          tile_out_valid,
   output logic                          tile_last,
   output logic                          busy,
   output logic                          done
);

   localparam int unsigned TILE_W = TILE_SIZE * WIDTH;
   localparam int unsigned SLOTS  = TILE_SIZE / IN_LANES;
   localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int unsigned CNT_W  = $clog2(TOTAL_ELEMENTS + 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    elem_cnt_q, elem_cnt_d;
   logic [SLOT_W-1:0]   slot_cnt_q, slot_cnt_d;
   logic [TILE_W-1:0]   fill_q, fill_d;
   logic [TILE_W-1:0]   out_q, out_d;
   logic                valid_q, valid_d;
   logic                last_q, last_d;
   logic                done_q, done_d;

   logic [IN_LANES*WIDTH-1:0] scaled_c;
   logic [TILE_W-1:0]         merged_c;
   logic [CNT_W-1:0]          step_c;
   logic                      start_c, accept_c, last_beat_c, tile_done_c;

   for (genvar j = 0; j < IN_LANES; j++) begin : g_lane
      qmul_scale #(
         .WIDTH      (WIDTH),
         .FRAC_WIDTH (FRAC_WIDTH),
         .SCALE_Q    (SCALE_Q)
      ) u_qmul (
         .x   (x_in[ms_lsb(j, IN_LANES, WIDTH) +: WIDTH]),
         .y_c (scaled_c[ms_lsb(j, IN_LANES, WIDTH) +: WIDTH])
      );
   end

   // Beat handshake and tile-boundary decode.
   always_comb begin : ctrl
      start_c     = en && start && (state_q != ST_FILL);
      accept_c    = en && x_in_valid && (state_q == ST_FILL);
      last_beat_c = accept_c && ((32'(elem_cnt_q) + IN_LANES) >= TOTAL_ELEMENTS);
      tile_done_c = accept_c && ((slot_cnt_q == SLOT_W'(SLOTS - 1)) || last_beat_c);
      step_c      = last_beat_c ? CNT_W'(TOTAL_ELEMENTS - 32'(elem_cnt_q)) : CNT_W'(IN_LANES);
   end

   // Current beat merged into the fill register; lanes past the row end are zeroed.
   always_comb begin : merge
      merged_c = fill_q;
      for (int unsigned j = 0; j < IN_LANES; j++) begin
         if ((32'(elem_cnt_q) + j) < TOTAL_ELEMENTS) begin
            merged_c[ms_lsb(32'(slot_cnt_q) * IN_LANES + j, TILE_SIZE, WIDTH) +: WIDTH] =
               scaled_c[ms_lsb(j, IN_LANES, WIDTH) +: WIDTH];
         end else begin
            merged_c[ms_lsb(32'(slot_cnt_q) * IN_LANES + j, TILE_SIZE, WIDTH) +: WIDTH] = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin : state_reg
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin : next_state
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_c)     state_d = ST_FILL;
         ST_FILL: if (last_beat_c) state_d = ST_DONE;
         ST_DONE: if (start_c)     state_d = ST_FILL;
         default:                  state_d = ST_IDLE;
      endcase
   end

   // Counters, double buffer and status; everything holds while en is low.
   always_comb begin : datapath
      elem_cnt_d = elem_cnt_q;
      slot_cnt_d = slot_cnt_q;
      fill_d     = fill_q;
      out_d      = out_q;
      valid_d    = valid_q;
      last_d     = last_q;
      done_d     = done_q;
      if (en) begin
         valid_d = tile_done_c;
         last_d  = tile_done_c && last_beat_c;
         if (start_c) begin
            elem_cnt_d = '0;
            slot_cnt_d = '0;
            fill_d     = '0;
            done_d     = 1'b0;
         end
         if (accept_c) begin
            elem_cnt_d = elem_cnt_q + step_c;
            if (tile_done_c) begin
               out_d      = merged_c;
               fill_d     = '0;
               slot_cnt_d = '0;
            end else begin
               fill_d     = merged_c;
               slot_cnt_d = slot_cnt_q + SLOT_W'(1);
            end
            if (last_beat_c) done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin : data_reg
      if (!rst_n) begin
         elem_cnt_q <= '0;
         slot_cnt_q <= '0;
         fill_q     <= '0;
         out_q      <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         elem_cnt_q <= elem_cnt_d;
         slot_cnt_q <= slot_cnt_d;
         fill_q     <= fill_d;
         out_q      <= out_d;
         valid_q    <= valid_d;
         last_q     <= last_d;
         done_q     <= done_d;
      end
   end

   // A tile pulse raised just before en drops stays hidden until en returns.
   assign tile_out_valid = valid_q && en;
   assign tile_last      = last_q && en;
   assign x_in_ready     = en && (state_q == ST_FILL);
   assign busy           = (state_q == ST_FILL);
   assign done           = done_q;
   assign X_tile_out     = out_q;

endmodule

// File: tb/tb_score_tile_packer.sv
// Scoreboard bench for score_tile_packer: four instances with different row/tile shapes
// share one input bus; each scenario starts one instance and tracks it cycle by cycle.
module tb_score_tile_packer;

   logic         clk, rst_n, en, x_in_valid;
   logic [3:0]   start;
   logic [127:0] x_in;
   logic [3:0]   rdy, tv, tl, bsy, dn;
   logic [511:0] t0, t1, t2;
   logic [127:0] t3;

   typedef struct packed {
      logic [511:0] d;
      logic         l;
   } tile_t;

   tile_t        exp_q[$];
   logic [511:0] seen_d[$];
   logic         seen_l[$];
   logic [31:0]  row_mem [32];
   logic [31:0]  m_tile [16];
   int           m_elem, m_slot;
   bit           m_fill, m_done, m_vq;
   int           checks = 0;
   int           errors = 0;

   score_tile_packer #(.TOTAL_ELEMENTS(32), .TILE_SIZE(16), .IN_LANES(4), .SCALE_Q(32'h0000_2000)) u0 (
      .clk(clk), .rst_n(rst_n), .en(en), .start(start[0]), .x_in(x_in), .x_in_valid(x_in_valid),
      .x_in_ready(rdy[0]), .X_tile_out(t0), .tile_out_valid(tv[0]), .tile_last(tl[0]),
      .busy(bsy[0]), .done(dn[0]));
   score_tile_packer #(.TOTAL_ELEMENTS(20), .TILE_SIZE(16), .IN_LANES(4), .SCALE_Q(32'h0000_2000)) u1 (
      .clk(clk), .rst_n(rst_n), .en(en), .start(start[1]), .x_in(x_in), .x_in_valid(x_in_valid),
      .x_in_ready(rdy[1]), .X_tile_out(t1), .tile_out_valid(tv[1]), .tile_last(tl[1]),
      .busy(bsy[1]), .done(dn[1]));
   score_tile_packer #(.TOTAL_ELEMENTS(18), .TILE_SIZE(16), .IN_LANES(4), .SCALE_Q(32'h0004_0000)) u2 (
      .clk(clk), .rst_n(rst_n), .en(en), .start(start[2]), .x_in(x_in), .x_in_valid(x_in_valid),
      .x_in_ready(rdy[2]), .X_tile_out(t2), .tile_out_valid(tv[2]), .tile_last(tl[2]),
      .busy(bsy[2]), .done(dn[2]));
   score_tile_packer #(.TOTAL_ELEMENTS(12), .TILE_SIZE(4), .IN_LANES(4), .SCALE_Q(32'h0000_2000)) u3 (
      .clk(clk), .rst_n(rst_n), .en(en), .start(start[3]), .x_in(x_in), .x_in_valid(x_in_valid),
      .x_in_ready(rdy[3]), .X_tile_out(t3), .tile_out_valid(tv[3]), .tile_last(tl[3]),
      .busy(bsy[3]), .done(dn[3]));

   always #5 clk = ~clk;

   function automatic logic [511:0] get_tile(input int k);
      case (k)
         0:       return t0;
         1:       return t1;
         2:       return t2;
         default: return {384'b0, t3};
      endcase
   endfunction

   function automatic logic [31:0] elem(input logic [511:0] d, input int tsz, input int i);
      return d[(tsz - 1 - i) * 32 +: 32];
   endfunction

   function automatic logic [31:0] model_scale(input logic [31:0] x, input logic [31:0] s);
      longint p, y;
      p = longint'($signed(x)) * longint'($signed(s));
      y = p >>> 16;
`ifdef SCORE_SAT_EN
      if (y > 64'sd2147483647) y = 64'sd2147483647;
      else if (y < -64'sd2147483648) y = -64'sd2147483648;
`endif
      return y[31:0];
   endfunction

   // Start instance k and stream its row, checking every cycle against the reference model.
   task automatic run_row(input int k, input int total, input int tsz, input logic [31:0] sq,
                          input bit gaps, input bit drop_en, input int max_beats);
      int           nbeats, beat, cyc, en_low, nslots, idx;
      bit           acc, comp, dropped, exp_v;
      tile_t        e;
      logic [511:0] obs, pk;
      nbeats = (total + 3) / 4;
      if (max_beats < nbeats) nbeats = max_beats;
      beat = 0; cyc = 0; en_low = 0; dropped = 0; nslots = tsz / 4;
      seen_d.delete(); seen_l.delete(); exp_q.delete();
      en = 1; x_in_valid = 0; start[k] = 1;
      @(posedge clk);
      m_fill = 1; m_elem = 0; m_slot = 0; m_done = 0; m_vq = 0;
      for (int i = 0; i < 16; i++) m_tile[i] = '0;
      #1 start[k] = 0;
      while ((beat < nbeats || exp_q.size() != 0) && cyc < 300) begin
         en = (en_low == 0);
         x_in_valid = (beat < nbeats) && (!gaps || ($urandom_range(0, 2) != 0));
         for (int j = 0; j < 4; j++) x_in[(3 - j) * 32 +: 32] = row_mem[(beat * 4 + j) % 32];
         @(negedge clk);
         checks += 4;
         if (rdy[k] !== (en && m_fill))
            begin errors++; $display("FAIL ready inst%0d cyc%0d got %b exp %b", k, cyc, rdy[k], en && m_fill); end
         if (bsy[k] !== m_fill)
            begin errors++; $display("FAIL busy inst%0d cyc%0d got %b exp %b", k, cyc, bsy[k], m_fill); end
         if (dn[k] !== m_done)
            begin errors++; $display("FAIL done inst%0d cyc%0d got %b exp %b", k, cyc, dn[k], m_done); end
         exp_v = m_vq && en;
         obs = get_tile(k);
         if (tv[k] !== exp_v)
            begin errors++; $display("FAIL tile_valid inst%0d cyc%0d got %b exp %b", k, cyc, tv[k], exp_v); end
         if (exp_v && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.d || tl[k] !== e.l) begin
               errors++;
               $display("FAIL tile_data inst%0d cyc%0d got %h/%b exp %h/%b", k, cyc, obs[127:0], tl[k], e.d[127:0], e.l);
            end
            seen_d.push_back(obs);
            seen_l.push_back(tl[k]);
         end
         acc = x_in_valid && en && m_fill;
         @(posedge clk);
         if (en_low > 0) en_low--;
         if (en) begin
            comp = 0;
            if (acc) begin
               for (int j = 0; j < 4; j++) begin
                  idx = m_slot * 4 + j;
                  m_tile[idx] = (m_elem + j < total) ? model_scale(row_mem[(beat * 4 + j) % 32], sq) : 32'h0;
               end
               m_elem += (total - m_elem < 4) ? (total - m_elem) : 4;
               comp = (m_slot == nslots - 1) || (m_elem >= total);
               if (comp) begin
                  pk = '0;
                  for (int i = 0; i < tsz; i++) pk[(tsz - 1 - i) * 32 +: 32] = m_tile[i];
                  exp_q.push_back('{d: pk, l: (m_elem >= total)});
                  for (int i = 0; i < 16; i++) m_tile[i] = '0;
                  m_slot = 0;
               end else begin
                  m_slot++;
               end
               if (m_elem >= total) begin m_fill = 0; m_done = 1; end
               beat++;
               if (comp && drop_en && !dropped) begin en_low = 3; dropped = 1; end
            end
            m_vq = comp;
         end
         #1;
         cyc++;
      end
      x_in_valid = 0;
      en = 1;
      checks++;
      if (cyc >= 300) begin errors++; $display("FAIL timeout inst%0d got %0d cycles exp <300", k, cyc); end
   endtask

   task automatic test_reset;
      #1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({rdy[k], tv[k], tl[k], bsy[k], dn[k]} !== 5'b0 || get_tile(k) !== 512'b0) begin
            errors++;
            $display("FAIL reset_init inst%0d got %b exp 00000", k, {rdy[k], tv[k], tl[k], bsy[k], dn[k]});
         end
      end
      @(negedge clk) rst_n = 1;
      for (int i = 0; i < 32; i++) row_mem[i] = 32'((i + 1) << 16);
      run_row(0, 32, 16, 32'h2000, 0, 0, 3);
      checks++;
      if (bsy[0] !== 1'b1) begin errors++; $display("FAIL busy_midrow got %b exp 1", bsy[0]); end
      #2 rst_n = 0;
      #1;
      checks++;
      if ({rdy[0], tv[0], tl[0], bsy[0], dn[0]} !== 5'b0 || t0 !== 512'b0) begin
         errors++;
         $display("FAIL reset_midrow got %b exp 00000", {rdy[0], tv[0], tl[0], bsy[0], dn[0]});
      end
      @(negedge clk) rst_n = 1;
      run_row(0, 32, 16, 32'h2000, 0, 0, 99);
      checks++;
      if (seen_d.size() != 2 || seen_l[0] !== 1'b0 || seen_l[1] !== 1'b1)
         begin errors++; $display("FAIL reset_rerun tiles got %0d exp 2", seen_d.size()); end
   endtask

   task automatic test_basic_row;
      for (int i = 0; i < 32; i++) row_mem[i] = 32'((i + 1) << 16);
      run_row(0, 32, 16, 32'h2000, 0, 0, 99);
      checks += 3;
      if (seen_d.size() != 2) begin
         errors++; $display("FAIL basic_count got %0d exp 2", seen_d.size());
      end else begin
         if (elem(seen_d[0], 16, 0) !== 32'h0000_2000)
            begin errors++; $display("FAIL basic_t0e0 got %h exp 00002000", elem(seen_d[0], 16, 0)); end
         if (elem(seen_d[1], 16, 15) !== 32'h0004_0000)
            begin errors++; $display("FAIL basic_t1e15 got %h exp 00040000", elem(seen_d[1], 16, 15)); end
      end
      @(negedge clk);
      checks++;
      if (dn[0] !== 1'b1 || tv[0] !== 1'b0)
         begin errors++; $display("FAIL basic_done got %b/%b exp 1/0", dn[0], tv[0]); end
   endtask

   task automatic test_partial_tile;
      for (int i = 0; i < 32; i++) row_mem[i] = 32'h0001_0000;
      run_row(1, 20, 16, 32'h2000, 0, 0, 99);
      checks++;
      if (seen_d.size() != 2) begin
         errors++; $display("FAIL partial_count got %0d exp 2", seen_d.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            checks++;
            if (elem(seen_d[1], 16, i) !== ((i < 4) ? 32'h0000_2000 : 32'h0))
               begin errors++; $display("FAIL partial_e%0d got %h", i, elem(seen_d[1], 16, i)); end
         end
         checks++;
         if (seen_l[1] !== 1'b1) begin errors++; $display("FAIL partial_last got %b exp 1", seen_l[1]); end
      end
   endtask

   task automatic test_ragged_last;
      for (int i = 0; i < 32; i++) row_mem[i] = (i < 18) ? 32'((i + 1) << 16) : 32'h7FFF_0000;
      run_row(2, 18, 16, 32'h0004_0000, 0, 0, 99);
      checks++;
      if (seen_d.size() != 2 || elem(seen_d[1], 16, 1) !== 32'h0048_0000 ||
          elem(seen_d[1], 16, 2) !== 32'h0 || elem(seen_d[1], 16, 3) !== 32'h0) begin
         errors++;
         $display("FAIL ragged tiles %0d got %h exp 00480000_00000000_00000000", seen_d.size(), seen_d[seen_d.size()-1][479:384]);
      end
   endtask

   task automatic test_saturation;
      logic [31:0] want;
`ifdef SCORE_SAT_EN
      want = 32'h7FFF_FFFF;
`else
      want = 32'hFFFC_0000;
`endif
      for (int i = 0; i < 32; i++) row_mem[i] = 32'h7FFF_0000;
      run_row(2, 18, 16, 32'h0004_0000, 0, 0, 99);
      checks++;
      if (seen_d.size() == 0 || elem(seen_d[0], 16, 0) !== want) begin
         errors++;
         $display("FAIL sat_e0 got %h exp %h", (seen_d.size() != 0) ? elem(seen_d[0], 16, 0) : 32'hx, want);
      end
   endtask

   task automatic test_en_gaps;
      for (int i = 0; i < 32; i++) row_mem[i] = $urandom;
      run_row(0, 32, 16, 32'h2000, 1, 1, 99);
      checks++;
      if (seen_d.size() != 2 || seen_l[0] !== 1'b0 || seen_l[1] !== 1'b1)
         begin errors++; $display("FAIL en_gaps tiles got %0d exp 2", seen_d.size()); end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 32; i++) row_mem[i] = 32'((i + 1) << 16) ^ 32'(i * 7);
      run_row(3, 12, 4, 32'h2000, 0, 0, 99);
      checks++;
      if (seen_d.size() != 3 || seen_l[2] !== 1'b1)
         begin errors++; $display("FAIL b2b tiles got %0d exp 3", seen_d.size()); end
   endtask

   initial begin
      clk = 0; rst_n = 0; en = 0; start = '0; x_in = '0; x_in_valid = 0;
      test_reset();
      test_basic_row();
      test_partial_tile();
      test_ragged_last();
      test_saturation();
      test_en_gaps();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
